// File: rtl/step_motor_ramp_ctrl.sv
// rtl/step_motor_ramp_ctrl.sv - stepper driver: manual keys, position seek, linear speed ramp, clamped position
module step_motor_ramp_ctrl #(
    parameter int POS_WIDTH    = 16,
    parameter int LIMIT_POS    = 75,
    parameter int CNT_WIDTH    = 22,
    parameter int PERIOD_START = 2_000_000,
    parameter int PERIOD_FAST  = 900_000,
    parameter int PERIOD_SLOW  = 1_600_000,
    parameter int RAMP_STEP    = 100_000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        engine_on,
    input  logic                        key_left,
    input  logic                        key_right,
    input  logic                        key_center,
    input  logic                        half_step,
    input  logic                        cmd_valid,
    input  logic signed [POS_WIDTH-1:0] cmd_target,
    output logic                        cmd_ready,
    output logic [3:0]                  step_out,
    output logic signed [POS_WIDTH-1:0] pos,
    output logic                        busy,
    output logic                        at_limit
);
    typedef enum logic [1:0] {S_IDLE, S_MANUAL, S_SEEK} state_t;

    localparam logic signed [POS_WIDTH-1:0] POS_LIM = POS_WIDTH'(LIMIT_POS);
    localparam logic signed [POS_WIDTH-1:0] NEG_LIM = -POS_LIM;
    localparam logic [CNT_WIDTH-1:0] START_P = CNT_WIDTH'(PERIOD_START);

    state_t                 state, state_nxt;
    logic signed [POS_WIDTH-1:0] tgt, tgt_nxt, seek_tgt, cmd_clamped, pos_nxt;
    logic [2:0]             phase, phase_nxt, phase_step;
    logic [3:0]             so_nxt;
    logic [CNT_WIDTH-1:0]   cnt, cnt_nxt, cnt_eff, period, period_nxt, per_eff, floor_p;
    logic [1:0]             last_dir, dir_nxt;
    logic                   man_req, seeking, up, dn, blocked, moving, reversal, fire;

    function automatic logic [3:0] coil_pattern(input logic [2:0] ph);
        case (ph)
            3'd0:    coil_pattern = 4'b1000;
            3'd1:    coil_pattern = 4'b1100;
            3'd2:    coil_pattern = 4'b0100;
            3'd3:    coil_pattern = 4'b0110;
            3'd4:    coil_pattern = 4'b0010;
            3'd5:    coil_pattern = 4'b0011;
            3'd6:    coil_pattern = 4'b0001;
            default: coil_pattern = 4'b1001;
        endcase
    endfunction

    assign man_req     = key_left ^ key_right;
    assign cmd_ready   = (state == S_IDLE) && !man_req && !key_center;
    assign busy        = (state != S_IDLE);
    assign at_limit    = (pos == POS_LIM) || (pos == NEG_LIM);
    assign floor_p     = engine_on ? CNT_WIDTH'(PERIOD_FAST) : CNT_WIDTH'(PERIOD_SLOW);
    assign cmd_clamped = (cmd_target > POS_LIM) ? POS_LIM :
                         (cmd_target < NEG_LIM) ? NEG_LIM : cmd_target;

    // Mode selection: manual keys beat centering, which beats a new command.
    always_comb begin
        state_nxt = state;
        seek_tgt  = tgt;
        seeking   = 1'b0;
        up        = 1'b0;
        dn        = 1'b0;
        if (man_req) begin
            state_nxt = S_MANUAL;
            up        = key_right;
            dn        = key_left;
        end else if (state == S_MANUAL) begin
            state_nxt = S_IDLE;
        end else if (key_center) begin
            seeking  = 1'b1;
            seek_tgt = '0;
        end else if (state == S_SEEK) begin
            seeking = 1'b1;
        end else if (cmd_valid) begin
            seeking  = 1'b1;
            seek_tgt = cmd_clamped;
        end
        if (seeking) begin
            state_nxt = S_SEEK;
            up        = seek_tgt > pos;
            dn        = seek_tgt < pos;
        end
    end

    assign tgt_nxt  = seeking ? seek_tgt : tgt;
    assign blocked  = (up && pos == POS_LIM) || (dn && pos == NEG_LIM);
    assign moving   = (up || dn) && !blocked;
    assign reversal = moving && (last_dir != 2'b00) && (last_dir != {dn, up});
    assign per_eff  = reversal ? START_P : ((period < floor_p) ? floor_p : period);
    assign cnt_eff  = reversal ? '0 : cnt;
    assign fire     = moving && (cnt_eff == per_eff - CNT_WIDTH'(1));

    // An odd phase in full-step mode takes a single index to land back on an even phase.
    always_comb begin
        if (half_step || phase[0])
            phase_step = up ? phase + 3'd1 : phase - 3'd1;
        else
            phase_step = up ? phase + 3'd2 : phase - 3'd2;
    end

    always_comb begin
        pos_nxt    = pos;
        phase_nxt  = phase;
        so_nxt     = step_out;
        cnt_nxt    = '0;
        period_nxt = per_eff;
        dir_nxt    = last_dir;
        if (moving) begin
            dir_nxt = {dn, up};
            if (fire) begin
                pos_nxt    = up ? pos + POS_WIDTH'(1) : pos - POS_WIDTH'(1);
                phase_nxt  = phase_step;
                so_nxt     = coil_pattern(phase_step);
                period_nxt = ({1'b0, per_eff} > {1'b0, floor_p} + (CNT_WIDTH + 1)'(RAMP_STEP)) ?
                             per_eff - CNT_WIDTH'(RAMP_STEP) : floor_p;
            end else begin
                cnt_nxt = cnt_eff + CNT_WIDTH'(1);
            end
        end else if (blocked) begin
            period_nxt = START_P;
            dir_nxt    = 2'b00;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            pos      <= '0;
            tgt      <= '0;
            phase    <= '0;
            step_out <= '0;
            cnt      <= '0;
            period   <= START_P;
            last_dir <= 2'b00;
        end else begin
            pos      <= pos_nxt;
            tgt      <= tgt_nxt;
            phase    <= phase_nxt;
            step_out <= so_nxt;
            if (seeking && pos_nxt == seek_tgt || state_nxt == S_IDLE) begin
                state    <= S_IDLE;
                cnt      <= '0;
                period   <= START_P;
                last_dir <= 2'b00;
            end else begin
                state    <= state_nxt;
                cnt      <= cnt_nxt;
                period   <= period_nxt;
                last_dir <= dir_nxt;
            end
        end
    end
endmodule

// File: tb/tb_step_motor_ramp_ctrl.sv
// tb/tb_step_motor_ramp_ctrl.sv - scoreboard bench for step_motor_ramp_ctrl with a cycle-level reference model
module tb_step_motor_ramp_ctrl;
    localparam int LIM = 3, START = 10, RAMP = 3, FAST = 4, SLOW = 7;

    logic clk = 1'b0, rst = 1'b1;
    logic engine_on = 1'b0, key_left = 1'b0, key_right = 1'b0, key_center = 1'b0;
    logic half_step = 1'b1, cmd_valid = 1'b0;
    logic signed [7:0] cmd_target = '0;
    logic cmd_ready, busy, at_limit;
    logic [3:0] step_out;
    logic signed [7:0] pos;

    step_motor_ramp_ctrl #(
        .POS_WIDTH(8), .LIMIT_POS(LIM), .CNT_WIDTH(8), .PERIOD_START(START),
        .PERIOD_FAST(FAST), .PERIOD_SLOW(SLOW), .RAMP_STEP(RAMP)
    ) dut (
        .clk(clk), .rst(rst), .engine_on(engine_on), .key_left(key_left),
        .key_right(key_right), .key_center(key_center), .half_step(half_step),
        .cmd_valid(cmd_valid), .cmd_target(cmd_target), .cmd_ready(cmd_ready),
        .step_out(step_out), .pos(pos), .busy(busy), .at_limit(at_limit)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {int cyc; int pos; logic [3:0] so;} ev_t;
    typedef struct {int pos; logic [3:0] so; logic busy; logic rdy; logic lim;} st_t;
    ev_t evq[$];
    st_t stq[$];

    int n_cmp = 0, n_err = 0;
    logic started = 1'b0;

    // Reference state: mode 0=idle 1=manual 2=seek; el = clocks spent toward the next step.
    int m_mode, m_pos, m_tgt, m_ph, m_per, m_el, m_last;
    logic [3:0] m_so;
    logic [3:0] tbl [8] = '{4'b1000, 4'b1100, 4'b0100, 4'b0110, 4'b0010, 4'b0011, 4'b0001, 4'b1001};

    task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_pos = 0; m_tgt = 0; m_ph = 0; m_so = 4'b0000;
        m_per = START; m_el = 0; m_last = 0;
    endtask

    task automatic model_step();
        int d, nm, fl, c;
        if (rst) begin
            model_reset();
            return;
        end
        d = 0; nm = 0;
        if (key_left != key_right) begin
            d = key_right ? 1 : -1; nm = 1;
        end else if (m_mode == 1) begin
            nm = 0;
        end else if (key_center || m_mode == 2 || cmd_valid) begin
            if (key_center) m_tgt = 0;
            else if (m_mode != 2) begin
                c = int'(cmd_target);
                m_tgt = (c > LIM) ? LIM : (c < -LIM) ? -LIM : c;
            end
            d = (m_tgt > m_pos) ? 1 : (m_tgt < m_pos) ? -1 : 0;
            nm = 2;
        end
        fl = engine_on ? FAST : SLOW;
        if (m_per < fl) m_per = fl;
        if (d != 0 && (m_pos + d) <= LIM && (m_pos + d) >= -LIM) begin
            if (m_last != 0 && d != m_last) begin
                m_per = START; m_el = 0;
            end
            m_last = d;
            m_el++;
            if (m_el == m_per) begin
                m_pos += d;
                if (half_step || (m_ph % 2) == 1) m_ph = (m_ph + d + 8) % 8;
                else m_ph = (m_ph + 2 * d + 8) % 8;
                m_so = tbl[m_ph];
                m_el = 0;
                m_per = (m_per - RAMP < fl) ? fl : m_per - RAMP;
            end
        end else begin
            m_el = 0;
            m_per = START;
            m_last = 0;
        end
        if (nm == 2 && m_pos == m_tgt) nm = 0;
        if (nm == 0) begin
            m_per = START; m_el = 0; m_last = 0;
        end
        m_mode = nm;
    endtask

    // Called just after a clock edge once inputs for the next edge are set.
    task automatic tick();
        st_t s;
        int old_pos;
        logic [3:0] old_so;
        s.pos = m_pos; s.so = m_so; s.busy = (m_mode != 0);
        s.rdy = (m_mode == 0) && (key_left == key_right) && !key_center;
        s.lim = (m_pos == LIM) || (m_pos == -LIM);
        stq.push_back(s);
        old_pos = m_pos; old_so = m_so;
        model_step();
        if (m_pos != old_pos || m_so != old_so)
            evq.push_back('{cyc: cyc + 1, pos: m_pos, so: m_so});
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic keys(input logic l, input logic r, input logic c);
        key_left = l; key_right = r; key_center = c;
    endtask

    int prev_pos = 0;
    logic [3:0] prev_so = 4'b0000;

    always @(negedge clk) begin
        if (started) begin
            if (stq.size() > 0) begin
                st_t s;
                s = stq.pop_front();
                chk("pos", pos, s.pos);
                chk("step_out", {28'd0, step_out}, {28'd0, s.so});
                chk("busy", {31'd0, busy}, {31'd0, s.busy});
                chk("cmd_ready", {31'd0, cmd_ready}, {31'd0, s.rdy});
                chk("at_limit", {31'd0, at_limit}, {31'd0, s.lim});
            end
            if (int'(pos) != prev_pos || step_out !== prev_so) begin
                if (evq.size() == 0) begin
                    chk("unexpected_step_pos", pos, prev_pos);
                end else begin
                    ev_t e;
                    e = evq.pop_front();
                    chk("step_cycle", cyc, e.cyc);
                    chk("step_pos", pos, e.pos);
                    chk("step_pattern", {28'd0, step_out}, {28'd0, e.so});
                end
            end
            prev_pos = int'(pos);
            prev_so  = step_out;
        end
    end

    initial begin
        @(posedge clk);
        #1;
        model_reset();
        started = 1'b1;
        run(2);
        rst = 1'b0;
        // Ramp to the right limit in half-step with the fast floor.
        engine_on = 1'b1; half_step = 1'b1;
        keys(1'b0, 1'b1, 1'b0); run(30);
        keys(1'b0, 1'b0, 1'b1); run(1);
        keys(1'b0, 1'b0, 1'b0); run(40);
        // Floor rises mid-move, then both keys give no request.
        keys(1'b0, 1'b1, 1'b0); run(19);
        engine_on = 1'b0; run(25);
        keys(1'b1, 1'b1, 1'b0); run(6);
        keys(1'b0, 1'b0, 1'b0); engine_on = 1'b1;
        // Command clamped to the negative limit in full-step.
        cmd_valid = 1'b1; cmd_target = -8'sd9; half_step = 1'b0; run(1);
        cmd_valid = 1'b0; run(50);
        // Seek toward +3 aborted by a reversing key.
        cmd_valid = 1'b1; cmd_target = 8'sd3; run(1);
        cmd_valid = 1'b0; run(14);
        keys(1'b1, 1'b0, 1'b0); run(25);
        keys(1'b0, 1'b0, 1'b0); run(2);
        // Reset mid-seek, then a command held through the busy period.
        cmd_valid = 1'b1; cmd_target = 8'sd3; run(1);
        cmd_valid = 1'b0; run(15);
        rst = 1'b1; run(1);
        rst = 1'b0; cmd_valid = 1'b1; cmd_target = -8'sd2; run(40);
        cmd_valid = 1'b0;
        for (int it = 0; it < 300; it++) begin
            int sel;
            sel = int'($urandom_range(0, 9));
            keys(sel == 0 || sel == 2, sel == 1 || sel == 2, 1'b0);
            engine_on  = 1'($urandom_range(0, 1));
            half_step  = 1'($urandom_range(0, 1));
            cmd_valid  = (sel >= 5);
            cmd_target = 8'(int'($urandom_range(0, 12)) - 6);
            rst        = ($urandom_range(0, 40) == 0);
            key_center = (sel == 3);
            run(1);
            rst = 1'b0; key_center = 1'b0;
            run(int'($urandom_range(1, 25)));
        end
        keys(1'b0, 1'b0, 1'b0); cmd_valid = 1'b0;
        run(3);
        @(negedge clk);
        #1;
        chk("events_drained", evq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
